// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: icache and dcache share one RAM port.
// dcache wins ties until icache has been starved STARVE_MAX times.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } state_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [2:0] starve_q, starve_d;
  ramstate_t  rs;
  logic       d_req;

  assign rs    = ramstate_t'(ramstate);
  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(iREN && starve_q == SMAX)) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          unique case (rs)
            ACCESS: begin
              iwait    = 1'b0;
              iload    = ramload;
              state_d  = IDLE;
              starve_d = '0;
            end
            ERROR:   state_d = IDLE;
            default: ;
          endcase
        end
      end
      DGNT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr = daddr;
          // write wins when both enables are up
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          unique case (rs)
            ACCESS: begin
              dwait   = 1'b0;
              dload   = dWEN ? 32'h0 : ramload;
              state_d = IDLE;
              if (iREN && starve_q < SMAX) begin
                starve_d = starve_q + 3'd1;
              end
            end
            ERROR:   state_d = IDLE;
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed checks of mem_arbiter against an
// owner/starvation model of the arbitration rules.
module tb_mem_arbiter;

  localparam int SMAX = 4;
  localparam int NONE = 0;
  localparam int OWN_I = 1;
  localparam int OWN_D = 2;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int errs;
  int checks;

  int owner;
  int starve;
  int nxt_owner;
  int nxt_starve;
  logic [131:0] exp_v;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected outputs and next owner from the arbitration rules
  task automatic model_eval();
    logic ew_i, ew_d, er, ewr;
    logic [31:0] ea, es, eil, edl;
    bit dreq;
    ew_i = 1; ew_d = 1; er = 0; ewr = 0;
    ea = 0; es = 0; eil = 0; edl = 0;
    dreq = dREN || dWEN;
    nxt_owner = owner;
    nxt_starve = starve;
    if (owner == NONE) begin
      if (dreq && !(iREN && starve == SMAX))
        nxt_owner = OWN_D;
      else if (iREN)
        nxt_owner = OWN_I;
    end else if (owner == OWN_I) begin
      if (!iREN) begin
        nxt_owner = NONE;
      end else begin
        er = 1; ea = iaddr;
        if (ramstate == 2'd2) begin
          ew_i = 0; eil = ramload;
          nxt_owner = NONE; nxt_starve = 0;
        end else if (ramstate == 2'd3) begin
          nxt_owner = NONE;
        end
      end
    end else begin
      if (!dreq) begin
        nxt_owner = NONE;
      end else begin
        ea = daddr;
        if (dWEN) begin ewr = 1; es = dstore; end
        else er = 1;
        if (ramstate == 2'd2) begin
          ew_d = 0;
          edl = dWEN ? 32'h0 : ramload;
          nxt_owner = NONE;
          if (iREN && starve < SMAX) nxt_starve = starve + 1;
        end else if (ramstate == 2'd3) begin
          nxt_owner = NONE;
        end
      end
    end
    exp_v = {ew_i, ew_d, er, ewr, eil, edl, ea, es};
  endtask

  task automatic settle();
    logic [131:0] act;
    #1;
    model_eval();
    act = {iwait, dwait, ramREN, ramWEN,
           iload, dload, ramaddr, ramstore};
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL cycle t=%0t: got %h want %h",
               $time, act, exp_v);
    end
    checks++;
    if (!iwait && !dwait) begin
      errs++;
      $display("FAIL both_wait_low: got 0 0 want not both 0");
    end
    checks++;
    if (ramREN && ramWEN) begin
      errs++;
      $display("FAIL ren_wen: got 1 1 want not both 1");
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    model_eval();
    if (!nRST) begin
      owner = NONE; starve = 0;
    end else begin
      owner = nxt_owner; starve = nxt_starve;
    end
    #1;
  endtask

  task automatic idle_in();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = 2'd0;
  endtask

  initial begin
    int dc, ic, d_before_i;
    errs = 0; checks = 0;
    owner = NONE; starve = 0;
    nRST = 0;
    idle_in();
    #3;
    settle();
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_ramaddr", ramaddr, 32'h0);
    @(posedge CLK); #1;
    #3 nRST = 1;
    adv();

    // single icache read, ACCESS on 2nd grant cycle
    iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
    settle();
    adv();
    settle();
    chk("i_ren", 32'(ramREN), 32'd1);
    chk("i_addr", ramaddr, 32'h40);
    chk("i_wait_busy", 32'(iwait), 32'd1);
    adv();
    ramstate = 2'd2; ramload = 32'h8C010004;
    settle();
    chk("i_wait_acc", 32'(iwait), 32'd0);
    chk("i_load", iload, 32'h8C010004);
    adv();
    iREN = 0;
    settle();
    chk("i_wait_after", 32'(iwait), 32'd1);
    chk("i_load_after", iload, 32'h0);
    adv();

    // simultaneous requests: dcache first
    iREN = 1; iaddr = 32'h44;
    dREN = 1; daddr = 32'h100;
    ramstate = 2'd2; ramload = 32'h11112222;
    settle();
    adv();
    settle();
    chk("tie_daddr", ramaddr, 32'h100);
    chk("tie_dwait", 32'(dwait), 32'd0);
    chk("tie_iwait", 32'(iwait), 32'd1);
    adv();
    dREN = 0;
    settle();
    chk("tie_bubble", 32'(ramREN), 32'd0);
    adv();
    settle();
    chk("tie_iaddr", ramaddr, 32'h44);
    chk("tie_iwait2", 32'(iwait), 32'd0);
    adv();

    // starvation limit
    dREN = 1; daddr = 32'h104;
    dc = 0; ic = 0; d_before_i = -1;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (!dwait) dc++;
      if (!iwait) begin
        if (ic == 0) d_before_i = dc;
        ic++;
      end
      adv();
    end
    chk("starve_d_first", d_before_i, 32'd4);
    chk("starve_icnt", ic, 32'd1);
    chk("starve_dcnt", dc, 32'd5);
    chk("model_starve", starve, 32'd1);
    iREN = 0; dREN = 0;
    settle();
    adv();

    // write with both enables high
    dREN = 1; dWEN = 1; daddr = 32'h200;
    dstore = 32'hDEADBEEF; ramload = 32'h12345678;
    settle();
    adv();
    settle();
    chk("w_wen", 32'(ramWEN), 32'd1);
    chk("w_ren", 32'(ramREN), 32'd0);
    chk("w_store", ramstore, 32'hDEADBEEF);
    chk("w_dload", dload, 32'h0);
    chk("w_dwait", 32'(dwait), 32'd0);
    adv();
    idle_in();

    // ERROR retry on icache
    iREN = 1; iaddr = 32'h80; ramstate = 2'd3;
    settle();
    adv();
    settle();
    chk("err_iwait", 32'(iwait), 32'd1);
    chk("err_addr", ramaddr, 32'h80);
    adv();
    ramstate = 2'd2; ramload = 32'hCAFE0001;
    settle();
    chk("err_idle", 32'(ramREN), 32'd0);
    adv();
    settle();
    chk("retry_addr", ramaddr, 32'h80);
    chk("retry_iwait", 32'(iwait), 32'd0);
    chk("retry_load", iload, 32'hCAFE0001);
    adv();
    idle_in();

    // reset during a BUSY dcache grant
    dREN = 1; daddr = 32'h300; ramstate = 2'd1;
    settle();
    adv();
    settle();
    chk("rb_ren", 32'(ramREN), 32'd1);
    #2 nRST = 0;
    #1;
    chk("rb_ren0", 32'(ramREN), 32'd0);
    chk("rb_addr0", ramaddr, 32'h0);
    chk("rb_dwait", 32'(dwait), 32'd1);
    owner = NONE; starve = 0;
    @(posedge CLK); #1;
    ramstate = 2'd2;
    settle();
    chk("rb_hold_dwait", 32'(dwait), 32'd1);
    #2 nRST = 1;
    adv();
    settle();
    chk("rb_restart", ramaddr, 32'h300);
    adv();
    idle_in();
    settle();
    adv();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      iREN   = ($urandom_range(99) < 70);
      dREN   = ($urandom_range(99) < 45);
      dWEN   = ($urandom_range(99) < 25);
      iaddr  = $urandom;
      daddr  = $urandom;
      dstore = $urandom;
      ramload = $urandom;
      r = $urandom_range(99);
      ramstate = (r < 40) ? 2'd2 :
                 (r < 70) ? 2'd1 :
                 (r < 85) ? 2'd0 : 2'd3;
      settle();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
